// File: rtl/sap_register_file.sv
// sap_register_file
//   Bank of DEPTH bus registers, WIDTH bits each, for the SAP data bus.
//   Addressed load, registered read with a one-cycle valid strobe, in-place
//   increment/decrement with carry/borrow and zero flags, and a combinational
//   debug view that never disturbs the bus output.
//
// Ports
//   clk            system clock, rising edge
//   clear_n        asynchronous active-low reset
//   data           bus input data
//   load/load_sel  write data into register load_sel
//   output_enable  read register out_sel onto data_out (1-cycle latency)
//   out_sel        read address
//   inc/dec        increment/decrement register op_sel (both high = no-op)
//   op_sel         inc/dec target
//   data_out       registered bus output, holds when not reading
//   data_out_valid high for one cycle after each accepted read
//   carry          carry/borrow from the last inc/dec
//   zero           last inc/dec result was zero
//   debug_sel      debug view address
//   debug_out      combinational view of register debug_sel
module sap_register_file #(
    parameter int                 WIDTH       = 8,
    parameter int                 DEPTH       = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       clear_n,
    input  logic [WIDTH-1:0]           data,
    input  logic                       load,
    input  logic [$clog2(DEPTH)-1:0]   load_sel,
    input  logic                       output_enable,
    input  logic [$clog2(DEPTH)-1:0]   out_sel,
    input  logic                       inc,
    input  logic                       dec,
    input  logic [$clog2(DEPTH)-1:0]   op_sel,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_out_valid,
    output logic                       carry,
    output logic                       zero,
    input  logic [$clog2(DEPTH)-1:0]   debug_sel,
    output logic [WIDTH-1:0]           debug_out
);

    localparam int AW = $clog2(DEPTH);
    // One extra bit so DEPTH itself is representable when it is a power of 2.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic             load_ok, out_ok, op_ok, debug_ok, op_go;
    logic [WIDTH-1:0] op_old, op_new;

    always_comb begin
        load_ok  = load && ({1'b0, load_sel} < DEPTH_W);
        out_ok   = {1'b0, out_sel} < DEPTH_W;
        op_ok    = {1'b0, op_sel} < DEPTH_W;
        debug_ok = {1'b0, debug_sel} < DEPTH_W;
        // A same-address load takes the register and leaves the flags alone.
        op_go    = (inc ^ dec) && op_ok && !(load_ok && (load_sel == op_sel));

        op_old   = op_ok ? regs_q[op_sel] : '0;
        op_new   = inc ? op_old + 1'b1 : op_old - 1'b1;

        regs_d     = regs_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        carry_d    = carry_q;
        zero_d     = zero_q;

        if (load_ok) begin
            regs_d[load_sel] = data;
        end
        if (op_go) begin
            regs_d[op_sel] = op_new;
            carry_d        = inc ? (&op_old) : ~(|op_old);
            zero_d         = (op_new == '0);
        end
        // Read samples regs_q, so collisions see the pre-update value.
        if (output_enable) begin
            data_out_d = out_ok ? regs_q[out_sel] : '0;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
            data_out_q <= '0;
            valid_q    <= 1'b0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign carry          = carry_q;
    assign zero           = zero_q;
    assign debug_out      = debug_ok ? regs_q[debug_sel] : '0;

endmodule
